// File: rtl/rand_pkg.sv
// Shared constants and the LFSR step function for the random word source.
package rand_pkg;

    localparam int unsigned RAND_W = 16;
    localparam logic [RAND_W-1:0] TAPS_DEFAULT = 16'hB400;
    localparam logic [RAND_W-1:0] SEED_DEFAULT = 16'hACE1;

    // One Galois LFSR step: shift right, fold taps in when the bit shifted out is 1.
    function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s,
                                                    input logic [RAND_W-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/rand_fifo.sv
// Generic synchronous FIFO with flush; head, count, empty and full are all registered.
module rand_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] nxt_rd_ptr;
    logic [PTR_W-1:0] nxt_wr_ptr;
    logic [CNT_W-1:0] nxt_cnt;
    logic [WIDTH-1:0] nxt_head;
    logic             do_push;
    logic             do_pop;

    // Next pointers, occupancy and head; a word written into the slot that becomes head bypasses mem.
    always_comb begin
        do_pop     = pop & ~empty;
        do_push    = push & (~full | do_pop);
        nxt_rd_ptr = rd_ptr + PTR_W'(do_pop);
        nxt_wr_ptr = wr_ptr + PTR_W'(do_push);
        nxt_cnt    = count;
        case ({do_push, do_pop})
            2'b10:   nxt_cnt = count + CNT_W'(1);
            2'b01:   nxt_cnt = count - CNT_W'(1);
            default: nxt_cnt = count;
        endcase
        nxt_head = '0;
        if (nxt_cnt != '0) begin
            if (do_push && (wr_ptr == nxt_rd_ptr)) begin
                nxt_head = din;
            end else begin
                nxt_head = mem[nxt_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            rd_ptr <= nxt_rd_ptr;
            wr_ptr <= nxt_wr_ptr;
            count  <= nxt_cnt;
            head   <= nxt_head;
            empty  <= (nxt_cnt == '0);
            full   <= (nxt_cnt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rand_source.sv
// LFSR-fed word FIFO supplying random operands, with software reseed and zero-seed flagging.
module rand_source #(
    parameter int unsigned DEPTH = 4,
    parameter logic [rand_pkg::RAND_W-1:0] TAPS = rand_pkg::TAPS_DEFAULT,
    parameter logic [rand_pkg::RAND_W-1:0] SEED_DEFAULT = rand_pkg::SEED_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        seed_load,
    input  logic [rand_pkg::RAND_W-1:0] seed_data,
    input  logic                        rd_req,
    output logic [rand_pkg::RAND_W-1:0] rand_data,
    output logic                        rand_valid,
    output logic [CNT_W-1:0]            fifo_cnt,
    output logic                        seed_err
);
    import rand_pkg::*;

    logic [RAND_W-1:0] lfsr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;

    // Reseed wins over both; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        pop  = rd_req & ~fifo_empty & ~seed_load;
        push = en & ~seed_load & (~fifo_full | pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr     <= SEED_DEFAULT;
            seed_err <= 1'b0;
        end else if (seed_load) begin
            lfsr <= (seed_data == '0) ? SEED_DEFAULT : seed_data;
            if (seed_data == '0) begin
                seed_err <= 1'b1;
            end
        end else if (push) begin
            lfsr <= lfsr_next(lfsr, TAPS);
        end
    end

    rand_fifo #(
        .WIDTH (RAND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (seed_load),
        .din   (lfsr),
        .head  (rand_data),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rand_valid = ~fifo_empty;

endmodule

// File: tb/tb_rand_source.sv
// Directed scoreboard bench for rand_source with hand-computed LFSR words.
module tb_rand_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_data;
    logic        rd_req;
    logic [15:0] rand_data;
    logic        rand_valid;
    logic [2:0]  fifo_cnt;
    logic        seed_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [15:0] d;
        logic        v;
        logic [2:0]  c;
        logic        e;
    } exp_t;

    exp_t sb[$];

    rand_source #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .rd_req     (rd_req),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .fifo_cnt   (fifo_cnt),
        .seed_err   (seed_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
        end
    endtask

    // Monitor: compares the outputs produced by the most recent edge against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.nm, "rand_data",  rand_data,          x.d);
            chk(x.nm, "rand_valid", 16'(rand_valid),    16'(x.v));
            chk(x.nm, "fifo_cnt",   16'(fifo_cnt),      16'(x.c));
            chk(x.nm, "seed_err",   16'(seed_err),      16'(x.e));
        end
    end

    // Drive one cycle's inputs just after an edge and queue what the next edge must produce.
    task automatic cyc(input logic rn, input logic en_i, input logic sl, input logic [15:0] sd,
                       input logic rd, input string nm, input logic [15:0] d, input logic v,
                       input logic [2:0] c, input logic e);
        exp_t x;
        #1;
        rst_n     = rn;
        en        = en_i;
        seed_load = sl;
        seed_data = sd;
        rd_req    = rd;
        @(posedge clk);
        x.nm = nm; x.d = d; x.v = v; x.c = c; x.e = e;
        sb.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fill_w [7];
        rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_data = '0; rd_req = 1'b0;
        @(posedge clk);

        cyc(0, 0, 0, 16'h0000, 0, "reset0", 16'h0000, 0, 0, 0);
        cyc(0, 1, 0, 16'h0000, 1, "reset1", 16'h0000, 0, 0, 0);

        // Fill: count 1..4 then saturates at full, head stays the first word.
        cyc(1, 1, 0, 16'h0000, 0, "fill1", 16'hACE1, 1, 1, 0);
        cyc(1, 1, 0, 16'h0000, 0, "fill2", 16'hACE1, 1, 2, 0);
        cyc(1, 1, 0, 16'h0000, 0, "fill3", 16'hACE1, 1, 3, 0);
        cyc(1, 1, 0, 16'h0000, 0, "fill4", 16'hACE1, 1, 4, 0);
        cyc(1, 1, 0, 16'h0000, 0, "full_hold", 16'hACE1, 1, 4, 0);

        // Push and pop together on full: head walks the LFSR sequence, count stays 4.
        fill_w[0] = 16'hE270; fill_w[1] = 16'h7138; fill_w[2] = 16'h389C; fill_w[3] = 16'h1C4E;
        fill_w[4] = 16'h0E27; fill_w[5] = 16'hB313; fill_w[6] = 16'hED89;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 0, 16'h0000, 1, $sformatf("stream%0d", i), fill_w[i], 1, 4, 0);
        end

        cyc(1, 0, 0, 16'h0000, 1, "pop_to3", 16'hC2C4, 1, 3, 0);

        // Reseed with rd_req high: flush, no pop, then words 0001 and B400.
        cyc(1, 1, 1, 16'h0001, 1, "seed_flush", 16'h0000, 0, 0, 0);
        cyc(1, 1, 0, 16'h0000, 0, "seed_w0", 16'h0001, 1, 1, 0);
        cyc(1, 1, 0, 16'h0000, 0, "seed_w1", 16'h0001, 1, 2, 0);
        cyc(1, 0, 0, 16'h0000, 1, "seed_pop", 16'hB400, 1, 1, 0);

        // Zero seed substitutes the default word and sets the sticky error.
        cyc(1, 0, 1, 16'h0000, 0, "zero_seed", 16'h0000, 0, 0, 1);
        cyc(1, 1, 0, 16'h0000, 0, "zero_w0", 16'hACE1, 1, 1, 1);
        cyc(1, 1, 0, 16'h0000, 0, "zero_w1", 16'hACE1, 1, 2, 1);
        cyc(1, 0, 1, 16'h1234, 0, "good_seed", 16'h0000, 0, 0, 1);
        cyc(1, 1, 0, 16'h0000, 0, "good_w0", 16'h1234, 1, 1, 1);
        cyc(1, 1, 0, 16'h0000, 0, "good_w1", 16'h1234, 1, 2, 1);

        // en low: drain the two words, extra requests ignored, LFSR holds.
        cyc(1, 0, 0, 16'h0000, 1, "drain1", 16'h091A, 1, 1, 1);
        cyc(1, 0, 0, 16'h0000, 1, "drain2", 16'h0000, 0, 0, 1);
        cyc(1, 0, 0, 16'h0000, 1, "empty_rd1", 16'h0000, 0, 0, 1);
        cyc(1, 0, 0, 16'h0000, 1, "empty_rd2", 16'h0000, 0, 0, 1);
        cyc(1, 1, 0, 16'h0000, 0, "hold_w0", 16'h048D, 1, 1, 1);
        cyc(1, 1, 0, 16'h0000, 0, "hold_w1", 16'h048D, 1, 2, 1);
        cyc(1, 1, 0, 16'h0000, 0, "hold_w2", 16'h048D, 1, 3, 1);

        // Mid-operation reset overrides a pending reseed and pop.
        cyc(0, 1, 1, 16'h5555, 1, "mid_reset", 16'h0000, 0, 0, 0);
        cyc(1, 1, 0, 16'h0000, 0, "post_reset", 16'hACE1, 1, 1, 0);

        @(negedge clk);
        #1;
        chk("scoreboard", "pending", 16'(sb.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_source.md
Name: rand_source

Overview:
- Pseudo-random word generator that supplies the rand_data operand of the instruction randomizer.
- A 16-bit Galois LFSR fills a small synchronous FIFO of precomputed words, so the issue path always has a random word ready.
- The consumer pops one word per randomized instruction.
- Supports software reseed with FIFO flush and flags illegal (all-zero) seeds.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TAPS, 16'hB400, Galois feedback polynomial mask.
- SEED_DEFAULT, 16'hACE1, LFSR value after reset and the substitute for a zero seed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  allow LFSR advance and FIFO fill.
- seed_load  in  1  load seed_data into LFSR and flush FIFO.
- seed_data  in  16  new seed.
- rd_req  in  1  consumer pop request.
- rand_data  out  16  FIFO head word; 0 when empty.
- rand_valid  out  1  FIFO non-empty.
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy.
- seed_err  out  1  sticky: a zero seed was loaded.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - lfsr=SEED_DEFAULT, fifo_cnt=0, rand_valid=0, rand_data=0, seed_err=0.
  - Reset overrides all other inputs, including mid-operation.
- LFSR step: next = (s>>1) ^ (s[0] ? TAPS : 0).
  - The LFSR advances only on a push, so consecutive FIFO words are consecutive LFSR states.
- pop = rd_req & rand_valid. rd_req on an empty FIFO is ignored; there is no underflow.
- push = en & ~seed_load & ((fifo_cnt<DEPTH) | pop).
  - A pop frees a slot in the same cycle, so push and pop together on a full FIFO keep fifo_cnt=DEPTH.
  - The pushed word is the current lfsr value. lfsr <= next on the same edge.
- fifo_cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output timing:
  - rand_data/rand_valid are registered-FIFO head values, with no combinational path from rd_req.
  - First word is visible 1 cycle after the first push edge.
- seed_load has priority over push and pop. On a seed_load edge:
  - FIFO is flushed: fifo_cnt=0, rand_valid=0, rand_data=0.
  - lfsr = (seed_data==0) ? SEED_DEFAULT : seed_data.
  - Any rd_req in that cycle is not a pop.
- seed_err is set on a seed_load with seed_data==0 and stays set until reset.
- en=0: LFSR holds and no pushes occur; pops continue until empty.
- The lfsr never holds 0; this is guaranteed by the zero-seed substitution.
- Read/write pointers wrap modulo DEPTH. Full is fifo_cnt==DEPTH, empty is fifo_cnt==0.

Decomposition:
- Package rand_pkg holds:
  - RAND_W=16
  - TAPS_DEFAULT=16'hB400
  - SEED_DEFAULT=16'hACE1
  - a function lfsr_next(s), shared with the verification model.
- Sub-module rand_fifo: generic synchronous FIFO with push, pop and flush; parameters WIDTH and DEPTH; outputs head, count, empty, full.
- The top level holds the LFSR register, seed logic and push/pop arbitration.

Test Plan:
- Reset, then en=1, rd_req=0 for 5 cycles:
  - fifo_cnt steps 1,2,3,4,4.
  - rand_data=ACE1, rand_valid=1.
  - Words stored are ACE1,E270,7138,389C; lfsr holds at 1C4E.
- From the full state, en=1 and rd_req=1 held for 7 cycles:
  - rand_data sequence is ACE1,E270,7138,389C,1C4E,0E27,B313.
  - fifo_cnt stays 4 throughout.
- seed_load=1 with seed_data=0001 while fifo_cnt=3, rd_req=1:
  - Next cycle: fifo_cnt=0, rand_valid=0, rand_data=0.
  - With en=1, subsequent words are 0001, B400.
- seed_load with seed_data=0000:
  - lfsr=ACE1 and seed_err=1.
  - seed_err stays 1 across a later valid seed_load; it clears only on rst_n=0.
- en=0 with fifo_cnt=2, rd_req=1 for 4 cycles:
  - Two pops occur, then fifo_cnt=0 and rand_valid=0.
  - Extra rd_req is ignored and fifo_cnt stays 0.
  - lfsr is unchanged.
- rst_n=0 for one edge while fifo_cnt=3 and seed_err=1:
  - All outputs return to reset values.
  - The next en=1 push yields ACE1.
